icb_console_slave: RTL and testbench

ICB_CONSOLE_SLAVE -- requirements
Module: icb_console_slave

---
 rtl/icb_console_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_icb_console_slave.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_console_slave.sv
// -----------------------------------------------------------------------------
// icb_console_slave
//
// ICB-attached console device. Bytes written to TXDATA are queued in a small
// FIFO and streamed out on a valid/ready character interface. A separate EXIT
// register lets software ask the simulation environment to stop with a code.
//
// Register map (offsets from BASE_ADDR, addr[1:0] ignored, 8 KB window):
//   0x000 TXDATA  write pushes wdata[7:0] when wmask[0]; read returns STATUS
//   0x004 STATUS  read-only: bit31 full, bit30 empty, [6:0] fill count
//   0x1000 EXIT   write latches wdata[7:0] into exit_code, sets exit_valid
//   Anything else (and writes to STATUS) -> err=1, rdata=0, no side effects.
//
// Parameters:
//   FIFO_DEPTH  TX FIFO entries, power of two in 2..64
//   BASE_ADDR   base of the decode window (8 KB aligned)
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   icb_cmd_valid/ready           command handshake
//   icb_cmd_addr/read/wdata/wmask command payload
//   icb_rsp_valid/ready           response handshake
//   icb_rsp_err/rdata             response payload
//   chr_valid/ready, chr_data     outgoing character stream
//   exit_valid, exit_code         sticky simulation exit request
//
// Optional feature macro: ICB_CONSOLE_CRLF_EN
//   When defined, each 8'h0A byte is emitted as 8'h0D followed by 8'h0A.
// -----------------------------------------------------------------------------
module icb_console_slave #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1004_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic [31:0] icb_cmd_addr,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic        icb_rsp_err,
  output logic [31:0] icb_rsp_rdata,
  output logic        chr_valid,
  input  logic        chr_ready,
  output logic [7:0]  chr_data,
  output logic        exit_valid,
  output logic [7:0]  exit_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Goes high on the first edge out of reset so cmd_ready is low while in reset.
  logic          up_reg;
  logic          rsp_valid_reg;
  logic          rsp_err_reg;
  logic [31:0]   rsp_rdata_reg;
  logic          exit_valid_reg;
  logic [7:0]    exit_code_reg;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic        in_window;
  logic [10:0] word_sel;
  logic        sel_tx;
  logic        sel_status;
  logic        sel_exit;

  assign in_window  = (icb_cmd_addr[31:13] == BASE_ADDR[31:13]);
  assign word_sel   = icb_cmd_addr[12:2];
  assign sel_tx     = in_window && (word_sel == 11'h000);
  assign sel_status = in_window && (word_sel == 11'h001);
  assign sel_exit   = in_window && (word_sel == 11'h400);

  // ---------------------------------------------------------------------------
  // FIFO status and character output
  // ---------------------------------------------------------------------------
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] status_word;
  logic [7:0]  head_byte;
  logic [7:0]  chr_out;
  logic        chr_fire;
  logic        pop;

  assign fifo_full   = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty  = (count_reg == '0);
  assign status_word = {fifo_full, fifo_empty, 23'd0, 7'(count_reg)};
  assign head_byte   = fifo_mem[rd_ptr_reg];
  assign chr_fire    = chr_valid && chr_ready;

`ifdef ICB_CONSOLE_CRLF_EN
  // Set once the CR for the current LF head byte has been handed over; the LF
  // itself is then presented and popped on the following handshake.
  logic crlf_sent_reg;
  logic lf_stage;

  assign lf_stage = (head_byte == 8'h0A) && !crlf_sent_reg;
  assign chr_out  = lf_stage ? 8'h0D : head_byte;
  assign pop      = chr_fire && !lf_stage;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crlf_sent_reg <= 1'b0;
    end else if (chr_fire) begin
      crlf_sent_reg <= lf_stage;
    end
  end
`else
  assign chr_out = head_byte;
  assign pop     = chr_fire;
`endif

  assign chr_valid = !fifo_empty;
  // Masked to zero when empty so stale RAM contents never leak out.
  assign chr_data  = fifo_empty ? 8'h00 : chr_out;

  // ---------------------------------------------------------------------------
  // Command acceptance
  // ---------------------------------------------------------------------------
  logic tx_write;
  logic tx_stall;
  logic accept;
  logic push;

  assign tx_write      = sel_tx && !icb_cmd_read;
  // A full FIFO only blocks the write when nothing drains it this cycle, so a
  // simultaneous push and pop at full goes through.
  assign tx_stall      = tx_write && fifo_full && !pop;
  assign icb_cmd_ready = up_reg && !rsp_valid_reg && !tx_stall;
  assign accept        = icb_cmd_valid && icb_cmd_ready;
  assign push          = accept && tx_write && icb_cmd_wmask[0];

  // ---------------------------------------------------------------------------
  // Response payload, computed from pre-update state
  // ---------------------------------------------------------------------------
  logic        rsp_err_next;
  logic [31:0] rsp_rdata_next;
  logic        exit_write;

  always_comb begin
    rsp_err_next   = 1'b0;
    rsp_rdata_next = 32'd0;
    exit_write     = 1'b0;
    if (sel_tx) begin
      if (icb_cmd_read) begin
        rsp_rdata_next = status_word;
      end
    end else if (sel_status) begin
      if (icb_cmd_read) begin
        rsp_rdata_next = status_word;
      end else begin
        rsp_err_next = 1'b1;
      end
    end else if (sel_exit) begin
      if (icb_cmd_read) begin
        rsp_rdata_next = {23'd0, exit_valid_reg, exit_code_reg};
      end else begin
        exit_write = 1'b1;
      end
    end else begin
      rsp_err_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_reg         <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_err_reg    <= 1'b0;
      rsp_rdata_reg  <= 32'd0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      exit_valid_reg <= 1'b0;
      exit_code_reg  <= 8'd0;
    end else begin
      up_reg <= 1'b1;

      // Accept is only possible with no response pending, so the two
      // branches never collide; payload changes only on acceptance.
      if (rsp_valid_reg && icb_rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
      if (accept) begin
        rsp_valid_reg <= 1'b1;
        rsp_err_reg   <= rsp_err_next;
        rsp_rdata_reg <= rsp_rdata_next;
      end

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (accept && exit_write) begin
        exit_valid_reg <= 1'b1;
        exit_code_reg  <= icb_cmd_wdata[7:0];
      end
    end
  end

  // FIFO storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr_reg] <= icb_cmd_wdata[7:0];
    end
  end

  assign icb_rsp_valid = rsp_valid_reg;
  assign icb_rsp_err   = rsp_err_reg;
  assign icb_rsp_rdata = rsp_rdata_reg;
  assign exit_valid    = exit_valid_reg;
  assign exit_code     = exit_code_reg;

  // Payload bits the register map does not use.
  logic unused_bits;
  assign unused_bits = ^{icb_cmd_wdata[31:8], icb_cmd_wmask[3:1], icb_cmd_addr[1:0]};

endmodule

// File: tb/tb_icb_console_slave.sv
// -----------------------------------------------------------------------------
// tb_icb_console_slave
//
// Directed scenarios followed by randomized ICB traffic. A monitor samples the
// DUT on every falling edge and compares it with a queue-based model of the
// console (byte queue, pending response, exit latch).
// -----------------------------------------------------------------------------
module tb_icb_console_slave;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h1004_0000;
`ifdef ICB_CONSOLE_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr = 32'd0;
  logic        icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_wdata = 32'd0;
  logic [3:0]  icb_cmd_wmask = 4'h0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b1;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        chr_valid;
  logic        chr_ready = 1'b0;
  logic [7:0]  chr_data;
  logic        exit_valid;
  logic [7:0]  exit_code;

  always #5 clk = ~clk;

  icb_console_slave #(
    .FIFO_DEPTH(DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icb_cmd_valid(icb_cmd_valid),
    .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr (icb_cmd_addr),
    .icb_cmd_read (icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid),
    .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_err  (icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata),
    .chr_valid    (chr_valid),
    .chr_ready    (chr_ready),
    .chr_data     (chr_data),
    .exit_valid   (exit_valid),
    .exit_code    (exit_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0]  tx_q[$];
  logic [7:0]  out_log[$];
  bit          m_up = 1'b0;
  bit          m_crlf = 1'b0;
  bit          m_rsp_valid = 1'b0;
  bit          m_rsp_err = 1'b0;
  bit          m_rsp_chk_data = 1'b0;
  logic [31:0] m_rsp_rdata = 32'd0;
  bit          m_exit_valid = 1'b0;
  logic [7:0]  m_exit_code = 8'd0;
  bit          prev_low = 1'b0;

  task automatic model_step();
    logic [31:0] status_pre;
    logic [31:0] off;
    logic [31:0] rel;
    logic [7:0]  head;
    logic [7:0]  exp_chr;
    bit nonempty, full, lf_first, hs, pop_ok, in_win, is_tx_wr, exp_ready;

    nonempty   = (tx_q.size() != 0);
    full       = (tx_q.size() == DEPTH);
    status_pre = 32'd0;
    status_pre[31]  = full;
    status_pre[30]  = !nonempty;
    status_pre[6:0] = 7'(tx_q.size());
    head     = nonempty ? tx_q[0] : 8'h00;
    lf_first = CRLF && nonempty && (head == 8'h0A) && !m_crlf;
    exp_chr  = lf_first ? 8'h0D : head;
    hs       = nonempty && chr_ready;
    pop_ok   = hs && !lf_first;

    off      = icb_cmd_addr - BASE;
    in_win   = (off < 32'h0000_2000);
    rel      = off & 32'h0000_1FFC;
    is_tx_wr = in_win && (rel == 32'd0) && !icb_cmd_read;
    exp_ready = m_up && !m_rsp_valid && !(is_tx_wr && full && !pop_ok);

    if (icb_cmd_valid)
      check_value("cmd_ready", 32'(icb_cmd_ready), 32'(exp_ready));
    else if (!m_up || m_rsp_valid)
      check_value("cmd_ready_idle", 32'(icb_cmd_ready), 32'd0);
    check_value("rsp_valid", 32'(icb_rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid) begin
      check_value("rsp_err", 32'(icb_rsp_err), 32'(m_rsp_err));
      if (m_rsp_chk_data) check_value("rsp_rdata", icb_rsp_rdata, m_rsp_rdata);
    end
    check_value("chr_valid", 32'(chr_valid), 32'(nonempty));
    if (nonempty) check_value("chr_data", 32'(chr_data), 32'(exp_chr));
    check_value("exit_valid", 32'(exit_valid), 32'(m_exit_valid));
    check_value("exit_code", 32'(exit_code), 32'(m_exit_code));

    if (chr_valid && chr_ready) out_log.push_back(chr_data);

    if (m_rsp_valid && icb_rsp_ready) m_rsp_valid = 1'b0;

    if (hs) begin
      if (lf_first) begin
        m_crlf = 1'b1;
      end else begin
        void'(tx_q.pop_front());
        m_crlf = 1'b0;
      end
    end

    if (icb_cmd_valid && exp_ready) begin
      m_rsp_valid    = 1'b1;
      m_rsp_err      = 1'b0;
      m_rsp_rdata    = 32'd0;
      m_rsp_chk_data = 1'b0;
      if (in_win && rel == 32'h0) begin
        if (icb_cmd_read) begin
          m_rsp_rdata = status_pre;
          m_rsp_chk_data = 1'b1;
        end else if (icb_cmd_wmask[0]) begin
          tx_q.push_back(icb_cmd_wdata[7:0]);
        end
      end else if (in_win && rel == 32'h4) begin
        m_rsp_chk_data = 1'b1;
        if (icb_cmd_read) m_rsp_rdata = status_pre;
        else m_rsp_err = 1'b1;
      end else if (in_win && rel == 32'h1000) begin
        if (!icb_cmd_read) begin
          m_exit_valid = 1'b1;
          m_exit_code  = icb_cmd_wdata[7:0];
        end
      end else begin
        m_rsp_err = 1'b1;
        m_rsp_chk_data = 1'b1;
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (prev_low) begin
          check_value("rst_cmd_ready", 32'(icb_cmd_ready), 32'd0);
          check_value("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
          check_value("rst_rsp_err", 32'(icb_rsp_err), 32'd0);
          check_value("rst_rsp_rdata", icb_rsp_rdata, 32'd0);
          check_value("rst_chr_valid", 32'(chr_valid), 32'd0);
          check_value("rst_chr_data", 32'(chr_data), 32'd0);
          check_value("rst_exit_valid", 32'(exit_valid), 32'd0);
          check_value("rst_exit_code", 32'(exit_code), 32'd0);
        end
        prev_low = 1'b1;
        tx_q.delete();
        m_up = 1'b0;
        m_crlf = 1'b0;
        m_rsp_valid = 1'b0;
        m_exit_valid = 1'b0;
        m_exit_code = 8'd0;
      end else begin
        prev_low = 1'b0;
        model_step();
        m_up = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Character sink
  // ---------------------------------------------------------------------------
  bit chr_rand = 1'b0;
  bit chr_fixed = 1'b1;

  initial begin : chr_driver
    forever begin
      @(posedge clk);
      #1;
      chr_ready = chr_rand ? 1'($urandom_range(0, 1)) : chr_fixed;
    end
  end

  // ---------------------------------------------------------------------------
  // ICB master
  // ---------------------------------------------------------------------------
  task automatic do_cmd(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int delay,
                        output logic [31:0] rdata, output int waited);
    int held;
    int tmo;
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = addr;
    icb_cmd_read  = rd;
    icb_cmd_wdata = wdata;
    icb_cmd_wmask = wmask;
    icb_rsp_ready = (delay == 0);
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (icb_cmd_ready) break;
      waited++;
      if (waited > 500) begin
        check_value("cmd_accept_timeout", 32'(icb_cmd_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    held = 0;
    tmo = 0;
    rdata = 32'd0;
    while (1) begin
      @(negedge clk);
      if (icb_rsp_valid && icb_rsp_ready) begin
        rdata = icb_rsp_rdata;
        break;
      end
      if (icb_rsp_valid) held++;
      tmo++;
      if (tmo > 100) begin
        check_value("rsp_timeout", 32'(icb_rsp_valid), 32'd1);
        break;
      end
      @(posedge clk);
      #1;
      if (held >= delay) icb_rsp_ready = 1'b1;
    end
  endtask

  logic [31:0] rd;
  int          waited;
  logic [7:0]  exp_seq[$];

  task automatic check_log(input string tag);
    check_value({tag, "_len"}, 32'(out_log.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++)
      check_value($sformatf("%s_chr%0d", tag, i),
                  (i < out_log.size()) ? 32'(out_log[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Simple string with sink always ready.
    chr_fixed = 1'b1;
    out_log.delete();
    do_cmd(BASE, 1'b0, 32'h48, 4'hF, 0, rd, waited);
    do_cmd(BASE, 1'b0, 32'h69, 4'hF, 0, rd, waited);
    do_cmd(BASE, 1'b0, 32'h0A, 4'hF, 0, rd, waited);
    repeat (6) @(posedge clk);
    if (CRLF) exp_seq = '{8'h48, 8'h69, 8'h0D, 8'h0A};
    else      exp_seq = '{8'h48, 8'h69, 8'h0A};
    check_log("hello");

    // Fill to capacity, observe the stall, then drain.
    chr_fixed = 1'b0;
    @(posedge clk);
    out_log.delete();
    exp_seq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      do_cmd(BASE, 1'b0, 32'h30 + i, 4'h1, 0, rd, waited);
      exp_seq.push_back(8'(8'h30 + i));
    end
    do_cmd(BASE + 32'h4, 1'b1, 32'd0, 4'h0, 0, rd, waited);
    check_value("status_full", rd, 32'h8000_0008);
    fork
      do_cmd(BASE, 1'b0, 32'h38 + DEPTH - 7, 4'hF, 0, rd, waited);
      begin
        repeat (12) @(posedge clk);
        #1;
        chr_fixed = 1'b1;
      end
    join
    exp_seq.push_back(8'(8'h38 + DEPTH - 7));
    check_value("stall_cycles_ge8", 32'(waited >= 8), 32'd1);
    repeat (15) @(posedge clk);
    check_log("fill");

    // Exit register.
    do_cmd(BASE + 32'h1000, 1'b0, 32'h06, 4'hF, 0, rd, waited);
    @(negedge clk);
    check_value("exit_code_first", 32'(exit_code), 32'd6);
    do_cmd(BASE + 32'h1000, 1'b0, 32'h04, 4'hF, 0, rd, waited);
    @(negedge clk);
    check_value("exit_code_second", 32'(exit_code), 32'd4);
    check_value("exit_valid_sticky", 32'(exit_valid), 32'd1);

    // Error accesses leave the queue untouched.
    chr_fixed = 1'b0;
    do_cmd(BASE, 1'b0, 32'hA1, 4'h1, 0, rd, waited);
    do_cmd(BASE, 1'b0, 32'hA2, 4'h1, 0, rd, waited);
    do_cmd(BASE + 32'h800, 1'b1, 32'd0, 4'h0, 0, rd, waited);
    check_value("bad_read_rdata", rd, 32'd0);
    do_cmd(BASE + 32'h4, 1'b0, 32'hFF, 4'hF, 0, rd, waited);
    do_cmd(BASE, 1'b0, 32'hA3, 4'h0, 0, rd, waited);
    // Response held back for five cycles.
    do_cmd(BASE + 32'h4, 1'b1, 32'd0, 4'h0, 5, rd, waited);
    check_value("status_after_err", rd, 32'h0000_0002);

    // Reset with bytes queued and a response outstanding.
    do_cmd(BASE, 1'b0, 32'h55, 4'h1, 0, rd, waited);
    @(posedge clk);
    #1;
    icb_cmd_addr  = BASE + 32'h4;
    icb_cmd_read  = 1'b1;
    icb_cmd_valid = 1'b1;
    icb_rsp_ready = 1'b0;
    @(negedge clk);
    check_value("pre_rst_accept", 32'(icb_cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    check_value("post_rst_chr_valid", 32'(chr_valid), 32'd0);
    check_value("post_rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    do_cmd(BASE + 32'h4, 1'b1, 32'd0, 4'h0, 0, rd, waited);
    check_value("post_rst_status", rd, 32'h4000_0000);

    // Randomized traffic against the model.
    chr_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
      int dl;
      op = $urandom_range(0, 9);
      d  = $urandom;
      if ($urandom_range(0, 5) == 0) d[7:0] = 8'h0A;
      m  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) m[0] = 1'b1;
      dl = $urandom_range(0, 3);
      a  = BASE + 32'($urandom_range(0, 3));
      case (op)
        0, 1, 2, 3, 4: do_cmd(a, 1'b0, d, m, dl, rd, waited);
        5:             do_cmd(a, 1'b1, d, m, dl, rd, waited);
        6:             do_cmd(a + 32'h4, 1'b1, d, m, dl, rd, waited);
        7:             do_cmd(a + 32'h4, 1'b0, d, m, dl, rd, waited);
        8:             do_cmd(a + 32'h1000, 1'b0, d, m, dl, rd, waited);
        default: begin
          case ($urandom_range(0, 4))
            0:       a = a + 32'h8;
            1:       a = a + 32'h800;
            2:       a = a + 32'h1FFC;
            3:       a = a - 32'h4;
            default: a = a + 32'h2000;
          endcase
          do_cmd(a, 1'($urandom_range(0, 1)), d, m, dl, rd, waited);
        end
      endcase
    end
    chr_rand = 1'b0;
    chr_fixed = 1'b1;
    repeat (2 * DEPTH + 6) @(posedge clk);
    @(negedge clk);
    check_value("final_drained", 32'(chr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
